// File: rtl/regfile_mp_sb.sv
// Multi-ported integer register file: NUM_RD combinational read ports, two write
// ports (ALU writeback on port 0, load writeback on port 1), optional same-cycle
// write-to-read bypass, and a per-register pending-write scoreboard for the issue
// stage's RAW-hazard stall logic. Register x0 reads as zero and is never pending.
module regfile_mp_sb #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we0,
  input  logic [ADDR_WIDTH-1:0]        waddr0,
  input  logic [DATA_WIDTH-1:0]        wdata0,
  input  logic                         we1,
  input  logic [ADDR_WIDTH-1:0]        waddr1,
  input  logic [DATA_WIDTH-1:0]        wdata1,
  input  logic                         sb_set,
  input  logic [ADDR_WIDTH-1:0]        sb_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  output logic [NUM_REGS-1:0]          busy_vec
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;

  // True when write port with enable we targets register index r.
  function automatic logic write_hits(input logic we, input logic [ADDR_WIDTH-1:0] waddr,
                                      input logic [ADDR_WIDTH-1:0] r);
    return we && (waddr == r);
  endfunction

  // Register array update: port 1 (load) overrides port 0 on a shared address; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (write_hits(we1, waddr1, ADDR_WIDTH'(r)))
          regs[r] <= wdata1;
        else if (write_hits(we0, waddr0, ADDR_WIDTH'(r)))
          regs[r] <= wdata0;
      end
    end
  end

  // Scoreboard: a new issue (set) beats a same-cycle writeback (clear) since it names a newer producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (sb_set && (sb_addr == ADDR_WIDTH'(r)))
          busy[r] <= 1'b1;
        else if (write_hits(we0, waddr0, ADDR_WIDTH'(r)) || write_hits(we1, waddr1, ADDR_WIDTH'(r)))
          busy[r] <= 1'b0;
      end
    end
  end

  assign busy_vec = busy;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit0;
    logic                  hit1;
    logic                  is_x0;

    assign ra    = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign is_x0 = (ra == '0);
    // Bypass hits only exist when forwarding is enabled; otherwise reads see stored state.
    assign hit1  = (BYPASS != 0) && write_hits(we1, waddr1, ra);
    assign hit0  = (BYPASS != 0) && write_hits(we0, waddr0, ra);

    // Read mux: x0 forced to zero, then load-port bypass, then ALU-port bypass, then array.
    always_comb begin
      rdata[i*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
      rbusy[i] = busy[ra];
      if (is_x0) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        rbusy[i] = 1'b0;
      end else if (hit1) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata1;
        rbusy[i] = 1'b0;
      end else if (hit0) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata0;
        rbusy[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed and model-checked bench for regfile_mp_sb: a bypassing and a
// non-bypassing 2-port/64-bit instance share stimulus; a 4-port/32-bit
// bypassing instance covers wide read packing and a randomized sequence.
module tb_regfile_mp_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         we0, we1, sb_set;
  logic [4:0]   waddr0, waddr1, sb_addr;
  logic [63:0]  wdata0, wdata1;
  logic [9:0]   raddr;
  logic [127:0] rdata_b, rdata_n;
  logic [1:0]   rbusy_b, rbusy_n;
  logic [31:0]  busy_b, busy_n;

  logic         we0_4, we1_4, sb_set_4;
  logic [4:0]   waddr0_4, waddr1_4, sb_addr_4;
  logic [31:0]  wdata0_4, wdata1_4;
  logic [19:0]  raddr_4;
  logic [127:0] rdata_4;
  logic [3:0]   rbusy_4;
  logic [31:0]  busy_4;

  int tests = 0;
  int fails = 0;

  regfile_mp_sb #(.DATA_WIDTH(64), .NUM_REGS(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .sb_set(sb_set), .sb_addr(sb_addr),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b), .busy_vec(busy_b));

  regfile_mp_sb #(.DATA_WIDTH(64), .NUM_REGS(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .sb_set(sb_set), .sb_addr(sb_addr),
    .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n), .busy_vec(busy_n));

  regfile_mp_sb #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .NUM_RD(4), .BYPASS(1)) dut_4 (
    .clk(clk), .rst(rst), .we0(we0_4), .waddr0(waddr0_4), .wdata0(wdata0_4),
    .we1(we1_4), .waddr1(waddr1_4), .wdata1(wdata1_4), .sb_set(sb_set_4), .sb_addr(sb_addr_4),
    .raddr(raddr_4), .rdata(rdata_4), .rbusy(rbusy_4), .busy_vec(busy_4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; sb_set = 0; waddr0 = 0; waddr1 = 0; sb_addr = 0;
    wdata0 = 0; wdata1 = 0;
    we0_4 = 0; we1_4 = 0; sb_set_4 = 0; waddr0_4 = 0; waddr1_4 = 0; sb_addr_4 = 0;
    wdata0_4 = 0; wdata1_4 = 0;
  endtask

  task automatic test_reset();
    idle();
    raddr = 0; raddr_4 = 0;
    rst = 1;
    we0 = 1; waddr0 = 5'd5; wdata0 = 64'hDEAD;
    tick();
    rst = 0;
    idle();
    for (int a = 0; a < 32; a++) begin
      raddr = {a[4:0], a[4:0]};
      #1;
      tests++;
      if (rdata_b !== 128'd0 || rbusy_b !== 2'b00) begin
        fails++;
        $display("FAIL reset_read_byp addr=%0d rdata=%h rbusy=%b expected 0/00", a, rdata_b, rbusy_b);
      end
      tests++;
      if (rdata_n !== 128'd0 || rbusy_n !== 2'b00) begin
        fails++;
        $display("FAIL reset_read_nobyp addr=%0d rdata=%h rbusy=%b expected 0/00", a, rdata_n, rbusy_n);
      end
    end
    tests++;
    if (busy_b !== 32'd0 || busy_n !== 32'd0 || busy_4 !== 32'd0) begin
      fails++;
      $display("FAIL reset_busy_vec got %h %h %h expected 0", busy_b, busy_n, busy_4);
    end
  endtask

  task automatic test_x0();
    idle();
    we0 = 1; waddr0 = 0; wdata0 = 64'hFFFF;
    tick();
    idle();
    raddr = 10'd0;
    #1;
    tests++;
    if (rdata_b !== 128'd0 || rdata_n !== 128'd0) begin
      fails++;
      $display("FAIL x0_write_dropped got %h / %h expected 0", rdata_b, rdata_n);
    end
    sb_set = 1; sb_addr = 0;
    tick();
    idle();
    tests++;
    if (busy_b !== 32'd0 || busy_n !== 32'd0) begin
      fails++;
      $display("FAIL x0_never_busy got %h / %h expected 0", busy_b, busy_n);
    end
  endtask

  task automatic test_dual_write();
    idle();
    we0 = 1; waddr0 = 5'd7; wdata0 = 64'h11;
    we1 = 1; waddr1 = 5'd7; wdata1 = 64'h22;
    raddr = {5'd7, 5'd7};
    #1;
    tests++;
    if (rdata_b !== {64'h22, 64'h22}) begin
      fails++;
      $display("FAIL dual_write_bypass got %h expected 22 on both ports", rdata_b);
    end
    tests++;
    if (rdata_n !== 128'd0) begin
      fails++;
      $display("FAIL dual_write_nobypass_same_cycle got %h expected 0", rdata_n);
    end
    tick();
    idle();
    tests++;
    if (rdata_b !== {64'h22, 64'h22} || rdata_n !== {64'h22, 64'h22}) begin
      fails++;
      $display("FAIL dual_write_port1_wins got %h / %h expected 22", rdata_b, rdata_n);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    sb_set = 1; sb_addr = 5'd3;
    tick();
    idle();
    raddr = {5'd0, 5'd3};
    #1;
    tests++;
    if (rbusy_b !== 2'b01 || rbusy_n !== 2'b01 || busy_b[3] !== 1'b1 || busy_n[3] !== 1'b1) begin
      fails++;
      $display("FAIL sb_set_visible rbusy=%b/%b busy3=%b/%b expected 01/01 1/1",
               rbusy_b, rbusy_n, busy_b[3], busy_n[3]);
    end
    we1 = 1; waddr1 = 5'd3; wdata1 = 64'h1234;
    #1;
    tests++;
    if (rdata_b[63:0] !== 64'h1234 || rbusy_b[0] !== 1'b0) begin
      fails++;
      $display("FAIL wb_bypass_same_cycle rdata=%h rbusy=%b expected 1234/0", rdata_b[63:0], rbusy_b[0]);
    end
    tests++;
    if (rdata_n[63:0] !== 64'h0 || rbusy_n[0] !== 1'b1) begin
      fails++;
      $display("FAIL wb_nobypass_same_cycle rdata=%h rbusy=%b expected 0/1", rdata_n[63:0], rbusy_n[0]);
    end
    tick();
    idle();
    tests++;
    if (busy_b[3] !== 1'b0 || busy_n[3] !== 1'b0 || rbusy_n[0] !== 1'b0 || rdata_n[63:0] !== 64'h1234) begin
      fails++;
      $display("FAIL wb_cleared_next busy3=%b/%b rbusy_n=%b rdata_n=%h expected 0/0 0 1234",
               busy_b[3], busy_n[3], rbusy_n[0], rdata_n[63:0]);
    end
  endtask

  task automatic test_set_wins();
    idle();
    sb_set = 1; sb_addr = 5'd9;
    tick();
    sb_set = 1; sb_addr = 5'd9;
    we0 = 1; waddr0 = 5'd9; wdata0 = 64'h55;
    tick();
    idle();
    raddr = {5'd9, 5'd9};
    #1;
    tests++;
    if (rdata_b !== {64'h55, 64'h55} || rdata_n !== {64'h55, 64'h55}) begin
      fails++;
      $display("FAIL set_wins_data got %h / %h expected 55", rdata_b, rdata_n);
    end
    tests++;
    if (busy_b[9] !== 1'b1 || busy_n[9] !== 1'b1 || rbusy_b !== 2'b11) begin
      fails++;
      $display("FAIL set_wins_busy busy9=%b/%b rbusy=%b expected 1/1 11", busy_b[9], busy_n[9], rbusy_b);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    raddr = {5'd10, 5'd10};
    we0 = 1; waddr0 = 5'd10; wdata0 = 64'hA1;
    #1;
    tests++;
    if (rdata_b[63:0] !== 64'hA1) begin
      fails++;
      $display("FAIL b2b_first_bypass got %h expected a1", rdata_b[63:0]);
    end
    tick();
    wdata0 = 64'hA2;
    #1;
    tests++;
    if (rdata_b[127:64] !== 64'hA2 || rdata_n[63:0] !== 64'hA1) begin
      fails++;
      $display("FAIL b2b_second got byp=%h nobyp=%h expected a2/a1", rdata_b[127:64], rdata_n[63:0]);
    end
    tick();
    idle();
    tests++;
    if (rdata_b[63:0] !== 64'hA2 || rdata_n[127:64] !== 64'hA2) begin
      fails++;
      $display("FAIL b2b_final got %h / %h expected a2", rdata_b[63:0], rdata_n[127:64]);
    end
  endtask

  task automatic test_rd4();
    idle();
    for (int k = 1; k <= 4; k++) begin
      we0_4 = 1; waddr0_4 = k[4:0]; wdata0_4 = k;
      tick();
    end
    idle();
    raddr_4 = {5'd1, 5'd2, 5'd3, 5'd4};
    #1;
    tests++;
    if (rdata_4 !== {32'd1, 32'd2, 32'd3, 32'd4} || rbusy_4 !== 4'b0000) begin
      fails++;
      $display("FAIL rd4_packing got %h rbusy=%b expected 00000001000000020000000300000004/0000",
               rdata_4, rbusy_4);
    end
  endtask

  task automatic test_random();
    logic [31:0]  mregs [32];
    logic [31:0]  mbusy;
    logic [31:0]  nbusy;
    logic [127:0] exp_rd;
    logic [3:0]   exp_rb;
    logic [4:0]   a;
    logic         r;
    idle();
    raddr_4 = 0;
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 32; k++) mregs[k] = 0;
    mbusy = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r = ($urandom_range(0, 199) == 0);
      rst = r;
      we0_4 = $urandom_range(0, 1);
      we1_4 = $urandom_range(0, 2) == 0;
      sb_set_4 = $urandom_range(0, 1);
      waddr0_4 = 5'($urandom_range(0, 7));
      waddr1_4 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      sb_addr_4 = 5'($urandom_range(0, 7));
      wdata0_4 = $urandom;
      wdata1_4 = $urandom;
      raddr_4 = 20'($urandom) & 20'h739CE;
      raddr_4[4:0] = 5'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < 4; p++) begin
        a = raddr_4[p*5 +: 5];
        if (a == 0) begin
          exp_rd[p*32 +: 32] = 0; exp_rb[p] = 0;
        end else if (we1_4 && waddr1_4 == a) begin
          exp_rd[p*32 +: 32] = wdata1_4; exp_rb[p] = 0;
        end else if (we0_4 && waddr0_4 == a) begin
          exp_rd[p*32 +: 32] = wdata0_4; exp_rb[p] = 0;
        end else begin
          exp_rd[p*32 +: 32] = mregs[a]; exp_rb[p] = mbusy[a];
        end
      end
      tests++;
      if (rdata_4 !== exp_rd || rbusy_4 !== exp_rb || busy_4 !== mbusy) begin
        fails++;
        $display("FAIL random cyc=%0d rdata=%h rbusy=%b busy=%h expected %h %b %h",
                 cyc, rdata_4, rbusy_4, busy_4, exp_rd, exp_rb, mbusy);
      end
      if (r) begin
        for (int k = 0; k < 32; k++) mregs[k] = 0;
        mbusy = 0;
      end else begin
        nbusy = mbusy;
        if (we0_4 && waddr0_4 != 0) begin mregs[waddr0_4] = wdata0_4; nbusy[waddr0_4] = 0; end
        if (we1_4 && waddr1_4 != 0) begin mregs[waddr1_4] = wdata1_4; nbusy[waddr1_4] = 0; end
        if (sb_set_4 && sb_addr_4 != 0) nbusy[sb_addr_4] = 1;
        mbusy = nbusy;
      end
      @(posedge clk);
      #1;
    end
    rst = 0;
    idle();
  endtask

  initial begin
    rst = 0;
    raddr = 0;
    raddr_4 = 0;
    idle();
    #2;
    test_reset();
    test_x0();
    test_dual_write();
    test_scoreboard();
    test_set_wins();
    test_back_to_back();
    test_rd4();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
